// File: rtl/conv_pkg.sv
// Shared parameters and FSM encoding for the convolution result readout path.
package conv_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } rd_state_t;

endpackage

// File: rtl/res_skid_fifo.sv
// Two-entry stream buffer; a push and a pop in the same cycle are legal even when full.
module res_skid_fifo #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] slot [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);
  assign rdata   = slot[rd_ptr];
  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      cnt     <= 2'd0;
    end else begin
      if (do_push) begin
        slot[wr_ptr] <= wdata;
        wr_ptr       <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/conv_result_reader.sv
// Drains the convolution result memory from address 0 and streams it out with valid/ready.
module conv_result_reader
  import conv_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] CNT_ONE = 1;

  rd_state_t       state;
  logic [ADDR_W:0] count_q;
  logic [ADDR_W:0] issued;
  logic [ADDR_W:0] accepted;
  logic            inflight;
  logic            rd_last;

  logic [DATA_W:0] fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            pop;
  logic [2:0]      used;
  logic            credit_ok;

  // A returning word bypasses the empty buffer so the first word appears one cycle after its read.
  assign out_valid = !fifo_empty || inflight;
  assign out_data  = !fifo_empty ? fifo_rdata[DATA_W-1:0] : (inflight ? mem_rdata : '0);
  assign out_last  = !fifo_empty ? fifo_rdata[DATA_W]     : (inflight && rd_last);
  assign pop       = out_valid && out_ready;
  assign fifo_pop  = out_ready && !fifo_empty;
  assign fifo_push = inflight && !(fifo_empty && out_ready);

  // A same-cycle pop returns its credit at once, which keeps the stream free of bubbles.
  assign used      = {1'b0, fifo_full, !fifo_full && !fifo_empty} + {2'b0, inflight};
  assign credit_ok = used < (3'd2 + {2'b0, pop});
  assign mem_re    = (state == S_READ) && (issued != count_q) && credit_ok;
  assign mem_addr  = issued[ADDR_W-1:0];

  res_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({rd_last, mem_rdata}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      count_q  <= '0;
      issued   <= '0;
      accepted <= '0;
      inflight <= 1'b0;
      rd_last  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inflight <= mem_re;
      done     <= 1'b0;
      if (mem_re) begin
        issued  <= issued + CNT_ONE;
        rd_last <= (issued == count_q - CNT_ONE);
      end
      if (pop) accepted <= accepted + CNT_ONE;
      case (state)
        S_IDLE: begin
          if (start) begin
            count_q  <= count;
            issued   <= '0;
            accepted <= '0;
            if (count == '0) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state <= S_READ;
              busy  <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (mem_re && (issued + CNT_ONE) == count_q) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && (accepted + CNT_ONE) == count_q) begin
            state <= S_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_result_reader.sv
// Directed and randomized checks of the result reader against a word-sequence reference model.
module tb_conv_result_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  count;
  logic        mem_re;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic [15:0] tb_mem [256];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // Synchronous-read result memory: data appears the cycle after the read enable.
  always @(posedge clk) if (mem_re) mem_rdata <= tb_mem[mem_addr];

  conv_result_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic readyFor(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 3) == 1;
      default: return 1'(($urandom & 1) != 0);
    endcase
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_mem_re"},    {31'd0, mem_re},    32'd0);
    checkOutput({tag, "_mem_addr"},  {24'd0, mem_addr},  32'd0);
    checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_out_data"},  {16'd0, out_data},  32'd0);
    checkOutput({tag, "_out_last"},  {31'd0, out_last},  32'd0);
    checkOutput({tag, "_busy"},      {31'd0, busy},      32'd0);
    checkOutput({tag, "_done"},      {31'd0, done},      32'd0);
  endtask

  // One run: the model expects mem[0..cnt-1] in order, last flag on the final word, done one cycle after it.
  task automatic applyStimulus(input int cnt, input int mode, input int abort_after, input bit restart);
    logic [16:0] exp_q [$];
    logic [16:0] w;
    logic [16:0] prev_word;
    bit          prev_stall;
    bit          finished;
    int          acc;
    int          issued_n;
    int          last_acc_cyc;
    int          budget;
    bit          exp_busy;
    bit          exp_done;

    for (int i = 0; i < cnt; i++) exp_q.push_back({1'(i == cnt - 1), tb_mem[i]});
    acc = 0; issued_n = 0; last_acc_cyc = -10; prev_stall = 0; finished = 0;
    budget = cnt * 4 + 20;

    @(posedge clk); #1;
    start = 1'b1; count = 9'(cnt); out_ready = readyFor(mode, 0);
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      start     = restart && (c == 3);
      count     = restart ? 9'(cnt + 5) : 9'(cnt);
      out_ready = readyFor(mode, c);
      @(negedge clk);
      exp_busy = (cnt != 0) && (acc < cnt);
      exp_done = (cnt == 0) ? (c == 1) : ((acc == cnt) && (c == last_acc_cyc + 1));
      checkOutput("busy", {31'd0, busy}, {31'd0, exp_busy});
      checkOutput("done", {31'd0, done}, {31'd0, exp_done});
      checkOutput("spurious_valid", {31'd0, out_valid && exp_q.size() == 0}, 32'd0);
      if (mem_re) begin
        checkOutput("mem_addr", {24'd0, mem_addr}, 32'(issued_n));
        checkOutput("outstanding", {31'd0, (issued_n - acc) <= 2}, 32'd1);
        issued_n++;
      end
      if (prev_stall) begin
        checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("stall_word", {15'd0, out_last, out_data}, {15'd0, prev_word});
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
      if (out_valid && out_ready && exp_q.size() != 0) begin
        w = exp_q.pop_front();
        checkOutput("out_data", {16'd0, out_data}, {16'd0, w[15:0]});
        checkOutput("out_last", {31'd0, out_last}, {31'd0, w[16]});
        if (mode == 0) checkOutput("no_bubble", 32'(c), 32'(acc + 2));
        acc++;
        if (acc == cnt) last_acc_cyc = c;
      end
      if (abort_after > 0 && acc == abort_after) begin
        finished = 1;
        break;
      end
      if (exp_done) begin
        finished = 1;
        break;
      end
    end
    if (!finished) checkOutput("timeout", 32'd0, 32'd1);

    if (abort_after > 0) begin
      @(posedge clk); #1; rst = 1'b1; start = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      checkIdleOutputs("abort");
    end else begin
      checkOutput("mem_re_count", 32'(issued_n), 32'(cnt));
      checkOutput("words_left", 32'(exp_q.size()), 32'd0);
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("post_busy",  {31'd0, busy},      32'd0);
        checkOutput("post_done",  {31'd0, done},      32'd0);
        checkOutput("post_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("post_re",    {31'd0, mem_re},    32'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; count = '0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;

    $display("[TB] count=4 streaming with ready held");
    tb_mem[0] = 16'd10; tb_mem[1] = 16'd20; tb_mem[2] = 16'd30; tb_mem[3] = 16'd40;
    applyStimulus(4, 0, 0, 0);

    $display("[TB] count=8 with ready pattern 1,0,0");
    for (int i = 0; i < 256; i++) tb_mem[i] = 16'($urandom);
    applyStimulus(8, 1, 0, 0);

    $display("[TB] count=0");
    applyStimulus(0, 0, 0, 0);

    $display("[TB] count=256 full address range");
    applyStimulus(256, 0, 0, 0);

    $display("[TB] reset after three words, then fresh count=2");
    applyStimulus(10, 0, 3, 0);
    applyStimulus(2, 0, 0, 0);

    $display("[TB] start pulsed again while busy");
    applyStimulus(6, 1, 0, 1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) tb_mem[i] = 16'($urandom);
      applyStimulus(int'($urandom_range(1, 40)), 2, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
